// File: rtl/core_ctrl_pkg.sv
// core_ctrl shared types: sequencer states, inst bit map, idle word.
// Imported by the sequencer top and its address/strobe generator.
package core_ctrl_pkg;

  localparam int IW = 34;
  localparam int AW = 11;
  localparam int CW = 16;

  typedef enum logic [3:0] {
    IDLE,
    KW_L0,
    KLOAD,
    GAP,
    AW_L0,
    EXEC,
    OFRD,
    ACC,
    DONE
  } state_t;

  localparam int ACC_B      = 33;
  localparam int CEN_P_B    = 32;
  localparam int WEN_P_B    = 31;
  localparam int AP_HI      = 30;
  localparam int AP_LO      = 20;
  localparam int CEN_X_B    = 19;
  localparam int WEN_X_B    = 18;
  localparam int AX_HI      = 17;
  localparam int AX_LO      = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXEC_B     = 1;
  localparam int LOAD_B     = 0;

  // Both SRAMs deselected and write-disabled; everything else off.
  localparam logic [IW-1:0] IDLE_INST =
    (IW'(1) << CEN_P_B) |
    (IW'(1) << WEN_P_B) |
    (IW'(1) << CEN_X_B) |
    (IW'(1) << WEN_X_B);

endpackage

// File: rtl/core_ctrl_lag.sv
// lag_rd_gen: SRAM read stream (CEN/addr) for step < len, plus a
// strobe lagging it by one step. Ports: en, base, stride, len, step.
module lag_rd_gen
  import core_ctrl_pkg::*;
(
  input  logic          en,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  input  logic [CW-1:0] len,
  input  logic [CW-1:0] step,
  output logic          cen,
  output logic [AW-1:0] addr,
  output logic          strobe
);

  logic rd;

  assign rd     = en && (step < len);
  assign cen    = !rd;
  assign addr   = rd ? base + AW'(step) * stride : '0;
  // Data of read n is captured one cycle later, so the strobe
  // covers steps 1..len.
  assign strobe = en && (step != '0) && (step <= len);

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer driving the 34-bit inst word of core.
// Ports: clk, reset, start, ofifo_valid -> inst, busy, done, kij_idx.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int          col         = 8,
  parameter int          len_kij     = 9,
  parameter int          len_nij     = 36,
  parameter int          len_onij    = 16,
  parameter int          load_cycles = 72,
  parameter int          gap_cycles  = 11,
  parameter logic [10:0] w_base      = 11'h400,
  parameter logic [10:0] a_base      = 11'h000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ofifo_valid,
  output logic [IW-1:0] inst,
  output logic          busy,
  output logic          done,
  output logic [3:0]    kij_idx
);

  if (len_kij * len_onij > 2048) begin : g_bad_pmem
    $error("len_kij*len_onij exceeds pmem range");
  end
  if (int'(w_base) + col > 2048) begin : g_bad_wbase
    $error("w_base+col exceeds xmem range");
  end
  if (int'(a_base) + len_nij > 2048) begin : g_bad_abase
    $error("a_base+len_nij exceeds xmem range");
  end
  if (len_kij > 16 || len_kij < 1) begin : g_bad_kij
    $error("len_kij must fit kij_idx");
  end

  localparam logic [CW-1:0] COL_C     = CW'(col);
  localparam logic [CW-1:0] LOAD_LAST = CW'(load_cycles - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(gap_cycles - 1);
  localparam logic [CW-1:0] NIJ_C     = CW'(len_nij);
  localparam logic [CW-1:0] ONIJ_C    = CW'(len_onij);
  localparam logic [CW-1:0] ONIJ_LAST = CW'(len_onij - 1);
  localparam logic [CW-1:0] KIJ_C     = CW'(len_kij);
  localparam logic [CW-1:0] ACC_LAST  = CW'(len_kij + 1);
  localparam logic [3:0]    KIJ_LAST  = 4'(len_kij - 1);
  localparam logic [AW-1:0] ONIJ_A    = AW'(len_onij);

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] o, o_n;
  logic [3:0]    kij, kij_n;
  logic [IW-1:0] inst_n;

  logic          g_en;
  logic [AW-1:0] g_base;
  logic [AW-1:0] g_stride;
  logic [CW-1:0] g_len;
  logic          g_cen;
  logic [AW-1:0] g_addr;
  logic          g_strobe;

  logic          is_lag;
  logic          is_kl;
  logic          is_ex;
  logic          is_of;
  logic          is_acc;
  logic          of_wr;
  logic [CW-1:0] of_idx;
  logic [AW-1:0] of_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= IDLE;
      cnt  <= '0;
      o    <= '0;
      kij  <= '0;
      inst <= IDLE_INST;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      o    <= o_n;
      kij  <= kij_n;
      inst <= inst_n;
      busy <= (st_n != IDLE) && (st_n != DONE);
      done <= (st_n == DONE);
    end
  end

  assign kij_idx = kij;

  // Next state. In OFRD, cnt counts pmem writes already issued,
  // including the one on inst in the current cycle.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    o_n   = o;
    kij_n = kij;
    unique case (st)
      IDLE: begin
        if (start) begin
          st_n  = KW_L0;
          cnt_n = '0;
          kij_n = '0;
        end
      end
      KW_L0: begin
        if (cnt == COL_C) begin
          st_n  = KLOAD;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      KLOAD: begin
        if (cnt == LOAD_LAST) begin
          st_n  = GAP;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          st_n  = AW_L0;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      AW_L0: begin
        if (cnt == NIJ_C) begin
          st_n  = EXEC;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      EXEC: begin
        if (cnt == ONIJ_LAST) begin
          st_n  = OFRD;
          cnt_n = CW'(ofifo_valid);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      OFRD: begin
        if (cnt == ONIJ_C) begin
          cnt_n = '0;
          if (kij == KIJ_LAST) begin
            st_n = ACC;
            o_n  = '0;
          end else begin
            st_n  = KW_L0;
            kij_n = kij + 4'd1;
          end
        end else begin
          cnt_n = cnt + CW'(ofifo_valid);
        end
      end
      ACC: begin
        if (cnt == ACC_LAST) begin
          cnt_n = '0;
          if (o == ONIJ_LAST) begin
            st_n = DONE;
          end else begin
            o_n = o + CW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        st_n = IDLE;
      end
      default: begin
        st_n = IDLE;
      end
    endcase
  end

  assign is_lag = (st_n == KW_L0) || (st_n == AW_L0);
  assign is_kl  = (st_n == KLOAD);
  assign is_ex  = (st_n == EXEC);
  assign is_of  = (st_n == OFRD);
  assign is_acc = (st_n == ACC);

  // inst is registered, so ofifo_valid seen at an edge produces
  // the pmem write in the cycle that follows it.
  assign of_wr   = is_of && ofifo_valid;
  assign of_idx  = (st == OFRD) ? cnt : '0;
  assign of_addr = AW'(kij) * ONIJ_A + AW'(of_idx);

  always_comb begin
    g_en     = 1'b0;
    g_base   = '0;
    g_stride = AW'(1);
    g_len    = '0;
    if (st_n == KW_L0) begin
      g_en   = 1'b1;
      g_base = w_base;
      g_len  = COL_C;
    end else if (st_n == AW_L0) begin
      g_en   = 1'b1;
      g_base = a_base;
      g_len  = NIJ_C;
    end else if (st_n == ACC) begin
      g_en     = 1'b1;
      g_base   = AW'(o_n);
      g_stride = ONIJ_A;
      g_len    = KIJ_C;
    end
  end

  lag_rd_gen u_lag (
    .en     (g_en),
    .base   (g_base),
    .stride (g_stride),
    .len    (g_len),
    .step   (cnt_n),
    .cen    (g_cen),
    .addr   (g_addr),
    .strobe (g_strobe)
  );

  always_comb begin
    inst_n = IDLE_INST;
    unique case (1'b1)
      is_lag: begin
        inst_n[CEN_X_B]     = g_cen;
        inst_n[AX_HI:AX_LO] = g_addr;
        inst_n[L0_WR_B]     = g_strobe;
      end
      is_kl: begin
        inst_n[LOAD_B]  = 1'b1;
        inst_n[L0_RD_B] = 1'b1;
      end
      is_ex: begin
        inst_n[EXEC_B]  = 1'b1;
        inst_n[L0_RD_B] = 1'b1;
      end
      is_of: begin
        if (of_wr) begin
          inst_n[OFIFO_RD_B]  = 1'b1;
          inst_n[CEN_P_B]     = 1'b0;
          inst_n[WEN_P_B]     = 1'b0;
          inst_n[AP_HI:AP_LO] = of_addr;
        end
      end
      is_acc: begin
        inst_n[CEN_P_B]     = g_cen;
        inst_n[AP_HI:AP_LO] = g_addr;
        inst_n[ACC_B]       = g_strobe;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl against a trace model built
// from per-phase loops over the kernel/output indices.
module tb_core_ctrl;

  localparam int COL  = 8;
  localparam int LKIJ = 9;
  localparam int LNIJ = 36;
  localparam int LON  = 16;
  localparam int LDC  = 72;
  localparam int GPC  = 11;
  localparam int WB   = 'h400;
  localparam int AB   = 'h000;
  localparam int PER_K = (COL + 1) + LDC + GPC + (LNIJ + 1) + 2 * LON;
  localparam int BUSY_CYC = LKIJ * PER_K + LON * (LKIJ + 2);

  logic        clk;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  int n_chk;
  int n_fail;

  logic [33:0] exp_w[$];
  int          exp_k[$];
  bit          vld[];
  logic [33:0] obs_w[$];
  bit          obs_d[$];
  bit          obs_b[$];
  int          obs_k[$];

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij_idx     (kij_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [33:0] idle_word();
    logic [33:0] w;
    w = '0;
    w[32] = 1'b1;
    w[31] = 1'b1;
    w[19] = 1'b1;
    w[18] = 1'b1;
    return w;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [33:0] w, input int k);
    exp_w.push_back(w);
    exp_k.push_back(k);
  endtask

  // Expected inst per cycle after the start edge; entry j is the
  // word following edge j, where vld[j] is ofifo_valid at edge j.
  task automatic build_model();
    logic [33:0] w;
    int wr;
    exp_w.delete();
    exp_k.delete();
    for (int k = 0; k < LKIJ; k++) begin
      for (int c = 0; c <= COL; c++) begin
        w = idle_word();
        if (c < COL) begin
          w[19] = 1'b0;
          w[17:7] = 11'(WB + c);
        end
        if (c >= 1) w[2] = 1'b1;
        push(w, k);
      end
      for (int c = 0; c < LDC; c++) begin
        w = idle_word();
        w[0] = 1'b1;
        w[3] = 1'b1;
        push(w, k);
      end
      for (int c = 0; c < GPC; c++) push(idle_word(), k);
      for (int c = 0; c <= LNIJ; c++) begin
        w = idle_word();
        if (c < LNIJ) begin
          w[19] = 1'b0;
          w[17:7] = 11'(AB + c);
        end
        if (c >= 1) w[2] = 1'b1;
        push(w, k);
      end
      for (int c = 0; c < LON; c++) begin
        w = idle_word();
        w[1] = 1'b1;
        w[3] = 1'b1;
        push(w, k);
      end
      wr = 0;
      while (wr < LON) begin
        w = idle_word();
        if (vld[exp_w.size()]) begin
          w[6] = 1'b1;
          w[32] = 1'b0;
          w[31] = 1'b0;
          w[30:20] = 11'(k * LON + wr);
          wr++;
        end
        push(w, k);
      end
    end
    for (int o = 0; o < LON; o++) begin
      for (int c = 0; c <= LKIJ + 1; c++) begin
        w = idle_word();
        if (c < LKIJ) begin
          w[32] = 1'b0;
          w[30:20] = 11'(c * LON + o);
        end
        if (c >= 1 && c <= LKIJ) w[33] = 1'b1;
        push(w, LKIJ - 1);
      end
    end
    push(idle_word(), LKIJ - 1);
    push(idle_word(), LKIJ - 1);
  endtask

  // mode 0: valid tied high, 1: alternating, 2: random.
  task automatic run_trace(input int mode, input bit noisy);
    int  di;
    bit  ok;
    bit  eb;
    bit  ed;
    vld = new[8000];
    foreach (vld[i]) begin
      if (mode == 0) vld[i] = 1'b1;
      else if (mode == 1) vld[i] = (i % 2) == 0;
      else vld[i] = $urandom_range(0, 1) == 1;
    end
    build_model();
    di = exp_w.size() - 2;
    obs_w.delete();
    obs_d.delete();
    obs_b.delete();
    obs_k.delete();
    ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    ofifo_valid = vld[0];
    for (int j = 0; j < exp_w.size(); j++) begin
      @(posedge clk);
      #1;
      obs_w.push_back(inst);
      obs_d.push_back(done);
      obs_b.push_back(busy);
      obs_k.push_back(int'(kij_idx));
      eb = j < di;
      ed = j == di;
      if (ok) begin
        n_chk++;
        if (inst !== exp_w[j] || busy !== eb || done !== ed ||
            (j <= di && int'(kij_idx) != exp_k[j])) begin
          n_fail++;
          ok = 1'b0;
          $display("FAIL trace m%0d c%0d: inst=%h busy=%b done=%b kij=%0d want %h %b %b %0d",
                   mode, j, inst, busy, done, kij_idx,
                   exp_w[j], eb, ed, exp_k[j]);
        end
      end
      start = noisy && (j < exp_w.size() - 3) &&
              ($urandom_range(0, 7) == 0);
      ofifo_valid = vld[j + 1];
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (inst !== 34'h1_800C_0000 || busy !== 1'b0 ||
        done !== 1'b0 || kij_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: inst=%h busy=%b done=%b kij=%0d",
               inst, busy, done, kij_idx);
    end
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk++;
    if (inst[17:7] !== 11'h400 || inst[19] !== 1'b0 ||
        inst[2] !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_word: A_xmem=%h cen=%b l0_wr=%b busy=%b",
               inst[17:7], inst[19], inst[2], busy);
    end
    do_reset(2);
  endtask

  task automatic test_kw_l0();
    int nwr;
    int first_wr;
    nwr = 0;
    first_wr = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c <= COL; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (inst[2]) begin
        nwr++;
        if (first_wr < 0) first_wr = c;
      end
      if (c < COL) begin
        n_chk++;
        if (inst[19] !== 1'b0 || inst[17:7] !== 11'(WB + c)) begin
          n_fail++;
          $display("FAIL kw_rd c%0d: cen=%b A=%h want 0 %h",
                   c, inst[19], inst[17:7], 11'(WB + c));
        end
      end else begin
        n_chk++;
        if (inst[19] !== 1'b1) begin
          n_fail++;
          $display("FAIL kw_last: cen=%b want 1", inst[19]);
        end
      end
    end
    n_chk++;
    if (nwr != COL || first_wr != 1) begin
      n_fail++;
      $display("FAIL kw_l0_wr: count=%0d first=%0d want %0d 1",
               nwr, first_wr, COL);
    end
    do_reset(2);
  endtask

  task automatic test_full_run();
    int prev;
    int steps;
    bit bad;
    int run;
    int runs;
    int badrun;
    int a5[$];
    int nd;
    int di;
    int nb;
    run_trace(0, 1'b0);
    prev = -1;
    steps = 0;
    bad = 1'b0;
    nd = 0;
    di = -1;
    nb = 0;
    for (int j = 0; j < obs_w.size(); j++) begin
      if (obs_d[j]) begin
        nd++;
        if (di < 0) di = j;
      end
      if (obs_b[j]) nb++;
      if (di < 0 && obs_k[j] != prev) begin
        if (obs_k[j] != prev + 1) bad = 1'b1;
        prev = obs_k[j];
        steps++;
      end
    end
    n_chk++;
    if (bad || steps != LKIJ || prev != LKIJ - 1) begin
      n_fail++;
      $display("FAIL kij_steps: steps=%0d last=%0d want %0d %0d",
               steps, prev, LKIJ, LKIJ - 1);
    end
    run = 0;
    runs = 0;
    badrun = 0;
    foreach (obs_w[j]) begin
      if (obs_w[j][33]) begin
        run++;
      end else if (run > 0) begin
        runs++;
        if (run != LKIJ) badrun++;
        run = 0;
      end
      if (!obs_w[j][32] && obs_w[j][31] &&
          (int'(obs_w[j][30:20]) % LON) == 5) begin
        a5.push_back(int'(obs_w[j][30:20]));
      end
    end
    n_chk++;
    if (runs != LON || badrun != 0) begin
      n_fail++;
      $display("FAIL acc_groups: groups=%0d bad=%0d want %0d 0",
               runs, badrun, LON);
    end
    n_chk++;
    if (a5.size() != LKIJ) begin
      n_fail++;
      $display("FAIL acc_o5_count: %0d want %0d", a5.size(), LKIJ);
    end
    for (int i = 0; i < a5.size(); i++) begin
      n_chk++;
      if (a5[i] != 5 + LON * i) begin
        n_fail++;
        $display("FAIL acc_o5[%0d]: A_pmem=%0d want %0d",
                 i, a5[i], 5 + LON * i);
      end
    end
    n_chk++;
    if (nd != 1 || di != BUSY_CYC || nb != BUSY_CYC) begin
      n_fail++;
      $display("FAIL totals: done=%0d at %0d busy=%0d want 1 %0d %0d",
               nd, di, nb, BUSY_CYC, BUSY_CYC);
    end
  endtask

  task automatic test_ofrd_toggle();
    int w2[$];
    int bad_rd;
    int bad_inv;
    bit wr;
    int a;
    run_trace(1, 1'b0);
    bad_rd = 0;
    bad_inv = 0;
    foreach (obs_w[j]) begin
      wr = !obs_w[j][32] && !obs_w[j][31];
      a = int'(obs_w[j][30:20]);
      if (wr != obs_w[j][6]) bad_rd++;
      if (wr && !vld[j]) bad_inv++;
      if (wr && a >= 32 && a <= 47) w2.push_back(a);
    end
    n_chk++;
    if (bad_rd != 0 || bad_inv != 0) begin
      n_fail++;
      $display("FAIL ofrd_strobe: rd_mis=%0d inval_wr=%0d want 0 0",
               bad_rd, bad_inv);
    end
    n_chk++;
    if (w2.size() != LON) begin
      n_fail++;
      $display("FAIL ofrd_k2_count: %0d want %0d", w2.size(), LON);
    end
    for (int i = 0; i < w2.size(); i++) begin
      n_chk++;
      if (w2[i] != 32 + i) begin
        n_fail++;
        $display("FAIL ofrd_k2[%0d]: A_pmem=%0d want %0d",
                 i, w2[i], 32 + i);
      end
    end
  endtask

  task automatic test_random_valid();
    for (int r = 0; r < 2; r++) run_trace(2, 1'b1);
  endtask

  task automatic test_reset_mid_exec();
    int t;
    bit hit;
    bit sawd;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    ofifo_valid = 1'b1;
    for (t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (kij_idx == 4'd4 && inst[1]) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL exec_k4_wait: timeout after %0d cycles", t);
    end
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if (inst !== idle_word() || busy !== 1'b0 || kij_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: inst=%h busy=%b kij=%0d",
               inst, busy, kij_idx);
    end
    sawd = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) sawd = 1'b1;
    end
    n_chk++;
    if (sawd) begin
      n_fail++;
      $display("FAIL post_reset: done/busy seen=%b want 0", sawd);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_chk++;
    if (kij_idx !== 4'd0 || inst[17:7] !== 11'h400 || inst[19] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: kij=%0d A=%h cen=%b want 0 400 0",
               kij_idx, inst[17:7], inst[19]);
    end
    do_reset(2);
  endtask

  task automatic test_start_reset_same();
    @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    n_chk++;
    if (inst !== idle_word() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_reset: inst=%h busy=%b", inst, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (inst !== idle_word() || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_reset_hold: inst=%h busy=%b done=%b",
               inst, busy, done);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    test_reset();
    test_kw_l0();
    test_full_run();
    test_ofrd_toggle();
    test_random_valid();
    test_reset_mid_exec();
    test_start_reset_same();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
